// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped read-only instruction cache with in-order line fill.
// A miss latches the line base and streams WORDS words from memory before returning to IDLE.
module icache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] instr,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  typedef enum logic {IDLE, FILL} state_t;
  state_t            r_state;
  logic [OW-1:0]     r_cnt;
  logic [LINES-1:0]  r_valid;
  logic [31:0]       r_base;
  logic [TW-1:0]     r_tag [LINES];
  logic [31:0]       r_data [LINES*WORDS];
  logic [IW-1:0]     w_idx, w_fidx;
  logic [OW-1:0]     w_off;
  logic              w_last;
  assign w_idx    = addr[2+OW +: IW];
  assign w_off    = addr[2 +: OW];
  assign w_fidx   = r_base[2+OW +: IW];
  assign w_last   = r_cnt == OW'(WORDS-1);
  assign hit      = r_state == IDLE && r_valid[w_idx] && r_tag[w_idx] == addr[31 -: TW];
  assign instr    = r_data[{w_idx, w_off}];
  assign mem_req  = r_state == FILL;
  assign mem_addr = mem_req ? r_base + 32'({r_cnt, 2'b00}) : 32'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      r_base  <= '0;
    end else begin
      if (flush) r_valid <= '0;
      if (r_state == IDLE) begin
        if (!hit && !flush) begin
          r_base  <= addr & ~32'(WORDS*4-1);
          r_cnt   <= '0;
          r_state <= FILL;
        end
      end else if (mem_ack) begin
        r_cnt <= r_cnt + 1'b1;
        // Set after the flush clear so a flush on the final ack leaves this line valid
        if (w_last) begin
          r_valid[w_fidx] <= 1'b1;
          r_state         <= IDLE;
        end
      end
    end
  always_ff @(posedge clk)
    if (r_state == FILL && mem_ack) begin
      r_data[{w_fidx, r_cnt}] <= mem_data;
      if (w_last) r_tag[w_fidx] <= r_base[31 -: TW];
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboarded directed + random check of icache_ctrl against a line-level cache model.
module tb_icache_ctrl;
  localparam int L = 16;
  localparam int W = 4;
  typedef struct packed {
    logic        hit;
    logic [31:0] instr;
    logic        req;
    logic [31:0] maddr;
  } exp_t;
  logic clk = 0, rst = 0, flush = 0, mem_ack = 0, hit, mem_req;
  logic [31:0] addr = 0, instr, mem_addr, mem_data, cur;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit m_valid[L];
  logic [31:0] m_base[L];
  bit m_busy;
  logic [31:0] m_fbase;
  int m_cnt;

  icache_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .hit(hit), .instr(instr), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  assign mem_data = memf(mem_addr);

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'(W*4)) % 32'(L));
  endfunction
  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~32'(W*4-1);
  endfunction
  function automatic bit m_hit(input logic [31:0] a);
    return !m_busy && m_valid[line_of(a)] && m_base[line_of(a)] == base_of(a);
  endfunction

  task automatic m_reset();
    m_busy = 0;
    m_cnt = 0;
    foreach (m_valid[i]) m_valid[i] = 0;
  endtask

  // Apply the inputs that were present at the clock edge just passed
  task automatic m_edge();
    bit h;
    if (rst) m_reset();
    else begin
      h = m_hit(addr);
      if (flush) foreach (m_valid[i]) m_valid[i] = 0;
      if (!m_busy) begin
        if (!h && !flush) begin
          m_busy = 1;
          m_fbase = base_of(addr);
          m_cnt = 0;
        end
      end else if (mem_ack) begin
        m_cnt++;
        if (m_cnt == W) begin
          m_valid[line_of(m_fbase)] = 1;
          m_base[line_of(m_fbase)] = m_fbase;
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic [31:0] a, input bit ack, input bit f, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    m_edge();
    addr = a;
    mem_ack = ack;
    flush = f;
    rst = r;
    if (r) m_reset();
    e.hit = m_hit(a);
    e.instr = memf(a & ~32'd3);
    e.req = m_busy;
    e.maddr = m_busy ? m_fbase + 32'(4 * m_cnt) : 32'd0;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hit", 32'(hit), 32'(e.hit));
      if (e.hit) chk("instr", instr, e.instr);
      chk("mem_req", 32'(mem_req), 32'(e.req));
      chk("mem_addr", mem_addr, e.maddr);
    end

  initial begin
    m_reset();
    #1 rst = 1;
    drive(0, 0, 0, 1);
    repeat (6) drive(32'h0, 1, 0, 0);
    drive(32'h8, 1, 0, 0);
    repeat (7) drive(32'h100, 1, 0, 0);
    repeat (7) drive(32'h0, 1, 0, 0);
    drive(32'h40, 0, 0, 0);
    repeat (4) begin
      repeat (3) drive(32'h40, 0, 0, 0);
      drive(32'h40, 1, 0, 0);
    end
    repeat (2) drive(32'h44, 0, 0, 0);
    drive(32'h200, 1, 0, 0);
    repeat (2) drive(32'h200, 1, 0, 0);
    drive(32'h200, 0, 0, 1);
    repeat (7) drive(32'h200, 1, 0, 0);
    drive(32'h204, 1, 1, 0);
    drive(32'h200, 1, 0, 0);
    repeat (3) drive(32'h208, 1, 0, 0);
    drive(32'h20C, 1, 1, 0);
    repeat (2) drive(32'h200, 0, 0, 0);
    drive(32'h0, 0, 0, 0);
    cur = 0;
    repeat (2000) begin
      if ($urandom_range(0, 3) == 0)
        cur = ($urandom_range(0, 15) == 0) ? $urandom :
              32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      drive(cur, $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
